// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller states, round count and the GF(2^8)
// helpers used by the round datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    WAIT,
    DONE
  } aes_state_e;

  localparam int AES_NR = 10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i sits at bits [8i+7:8i] with i = row + 4*column.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(4*c+0) +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      o[8*(4*c+0) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_round_tail.sv
// Combinational round tail applied to the sub_bytes result: ShiftRows, then
// MixColumns unless this is the final round.
module aes_round_tail
  import aes_pkg::*;
(
  input  logic [127:0] i_data,
  input  logic         i_final_round,
  output logic [127:0] o_data
);

  logic [127:0] w_shifted;

  assign w_shifted = shift_rows(i_data);
  assign o_data    = i_final_round ? w_shifted : mix_columns(w_shifted);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer driving an external shared sub_bytes
// unit; one round per SUB/WAIT pair, ciphertext held in DONE until taken.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int SBOX_LAT = 1,
  parameter int NR       = AES_NR,
  parameter int TIMEOUT  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         sb_valid,
  output logic [127:0] sb_data_in,
  input  logic         sb_out_valid,
  input  logic [127:0] sb_data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_out,
  output logic         err
);

  // A timeout not longer than the S-box latency could never be met, so clamp it.
  localparam int             TO_LIMIT   = (TIMEOUT > SBOX_LAT) ? TIMEOUT : SBOX_LAT + 1;
  localparam int             CW         = $clog2(TO_LIMIT + 1);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(TO_LIMIT - 1);
  localparam logic [3:0]     LAST_ROUND = 4'(NR);

  aes_state_e    r_fsm, w_next;
  logic [127:0]  r_data;
  logic [3:0]    r_round;
  logic [CW-1:0] r_waitCnt;
  logic          r_err;
  logic [127:0]  w_tail;
  logic          w_final;
  logic          w_timeout;

  assign w_final   = (r_round == LAST_ROUND);
  assign w_timeout = (r_fsm == WAIT) && !sb_out_valid && (r_waitCnt == CNT_LAST);

  aes_round_tail u_tail (
    .i_data        (sb_data_out),
    .i_final_round (w_final),
    .o_data        (w_tail)
  );

  always_comb begin
    w_next = r_fsm;
    case (r_fsm)
      IDLE:    if (in_valid) w_next = SUB;
      SUB:     w_next = WAIT;
      WAIT: begin
        if (sb_out_valid)   w_next = w_final ? DONE : SUB;
        else if (w_timeout) w_next = IDLE;
      end
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign in_ready   = (r_fsm == IDLE);
  assign sb_valid   = (r_fsm == SUB);
  assign sb_data_in = sb_valid ? r_data : '0;
  assign rk_idx     = ((r_fsm == SUB) || (r_fsm == WAIT)) ? r_round : 4'd0;
  assign out_valid  = (r_fsm == DONE);
  assign ct_out     = out_valid ? r_data : '0;
  assign err        = r_err;

  // Results arriving outside WAIT are never folded into the state, only flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm     <= IDLE;
      r_data    <= '0;
      r_round   <= '0;
      r_waitCnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_fsm <= w_next;
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_data  <= pt_in ^ rk_in;
            r_round <= 4'd1;
          end
        end
        SUB: r_waitCnt <= '0;
        WAIT: begin
          if (sb_out_valid) begin
            r_data <= w_tail ^ rk_in;
            if (!w_final) r_round <= r_round + 4'd1;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (w_timeout || (sb_out_valid && (r_fsm != WAIT))) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: external sub_bytes and key store
// models plus a byte-level AES-128 reference cipher.
module tb_aes_round_ctrl;

  localparam int NR         = 10;
  localparam int SBOX_LAT   = 1;
  localparam int TIMEOUT    = 16;
  localparam int LAT        = NR * (1 + SBOX_LAT);
  localparam int PERIOD_BLK = LAT + 2;
  localparam int NWORDS     = 4 * (NR + 1);

  localparam logic [127:0] FIPS_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] FIPS_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] FIPS_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic         sb_valid;
  logic [127:0] sb_data_in;
  logic         sb_out_valid;
  logic [127:0] sb_data_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct_out;
  logic         err;

  logic [7:0]   sboxTab [256];
  logic [127:0] rkBus [16];
  logic         sbValidQ;
  logic [127:0] sbDataQ;
  bit           suppress = 1'b0;
  bit           spurious = 1'b0;
  int           errors = 0;
  int           checks = 0;
  int           cycleCnt = 0;
  int           sbPulses = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.SBOX_LAT(SBOX_LAT), .NR(NR), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pt_in        (pt_in),
    .rk_idx       (rk_idx),
    .rk_in        (rk_in),
    .sb_valid     (sb_valid),
    .sb_data_in   (sb_data_in),
    .sb_out_valid (sb_out_valid),
    .sb_data_out  (sb_data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ct_out       (ct_out),
    .err          (err)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  function automatic logic [127:0] subAll(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sboxTab[s[8*i +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Byte-array AES-128 straight from the cipher definition, using rkBus as the schedule.
  function automatic logic [127:0] refEncrypt(input logic [127:0] pt);
    logic [7:0]   st [16];
    logic [7:0]   t  [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) st[i] = pt[8*i +: 8] ^ rkBus[0][8*i +: 8];
    for (int rnd = 1; rnd <= NR; rnd++) begin
      for (int i = 0; i < 16; i++) st[i] = sboxTab[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = st[r+4*((c+r)%4)];
      if (rnd < NR) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            st[r+4*c] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                      ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      end else begin
        st = t;
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rkBus[rnd][8*i +: 8];
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = st[i];
    return o;
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sboxTab[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic setKey(input logic [127:0] key);
    logic [7:0] w [NWORDS][4];
    logic [7:0] tmp [4];
    logic [7:0] rc;
    logic [7:0] x;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) w[i][k] = key[8*(4*i+k) +: 8];
    for (int i = 4; i < NWORDS; i++) begin
      for (int k = 0; k < 4; k++) tmp[k] = w[i-1][k];
      if (i % 4 == 0) begin
        x      = tmp[0];
        tmp[0] = sboxTab[tmp[1]] ^ rc;
        tmp[1] = sboxTab[tmp[2]];
        tmp[2] = sboxTab[tmp[3]];
        tmp[3] = sboxTab[x];
        rc     = gmul(rc, 8'h02);
      end
      for (int k = 0; k < 4; k++) w[i][k] = w[i-4][k] ^ tmp[k];
    end
    for (int r = 0; r < 16; r++) rkBus[r] = '0;
    for (int r = 0; r <= NR; r++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++) rkBus[r][8*(4*j+k) +: 8] = w[4*r+j][k];
  endtask

  // Key store answers combinationally; sub_bytes model is a one-cycle pipeline.
  assign rk_in        = rkBus[rk_idx];
  assign sb_out_valid = sbValidQ | spurious;
  assign sb_data_out  = sbDataQ;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sbValidQ <= 1'b0;
      sbDataQ  <= '0;
    end else begin
      sbValidQ <= sb_valid && !suppress;
      sbDataQ  <= subAll(sb_data_in);
    end
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;
  always @(negedge clk) if (sb_valid) sbPulses <= sbPulses + 1;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one block from a negedge, holds DONE for holdCycles extra cycles, ends at a negedge.
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] expCt, input int holdCycles);
    int n;
    int p0;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("readyBeforeAccept", in_ready, 1);
    in_valid = 1'b1;
    pt_in    = pt;
    p0       = sbPulses;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    pt_in    = rand128();
    n = 0;
    while (!out_valid && n < 100) begin
      checkOutput("readyLowBusy", in_ready, 0);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checkOutput("latency", n, LAT);
    checkOutput("sbPulses", sbPulses - p0, NR);
    checkOutput("ciphertext", ct_out, expCt);
    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("holdValid", out_valid, 1);
      checkOutput("holdCt", ct_out, expCt);
      checkOutput("holdReadyLow", in_ready, 0);
    end
    out_ready = 1'b1;
    checkOutput("handoffReadyLow", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("validDropped", out_valid, 0);
    checkOutput("ctZeroed", ct_out, 0);
    checkOutput("readyAfterHandoff", in_ready, 1);
  endtask

  task automatic backToBack();
    logic [127:0] blk [3];
    int  accCyc [3];
    int  inIdx, outIdx;
    bit  busy, prevAccept, prevHand;
    for (int i = 0; i < 3; i++) blk[i] = rand128();
    inIdx = 0; outIdx = 0; busy = 0; prevAccept = 0; prevHand = 0;
    for (int i = 0; i < 3; i++) accCyc[i] = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    pt_in     = blk[0];
    for (int cyc = 0; cyc < 200 && outIdx < 3; cyc++) begin
      if (prevAccept) busy = 1;
      if (prevHand) busy = 0;
      checkOutput("b2bReadyIdleOnly", in_ready, !busy);
      prevAccept = 0;
      prevHand   = 0;
      if (out_valid) begin
        checkOutput("b2bCiphertext", ct_out, refEncrypt(blk[outIdx]));
        checkOutput("b2bLatency", cycleCnt - accCyc[outIdx] - 1, LAT);
        outIdx++;
        prevHand = 1;
      end
      if (in_ready && in_valid && inIdx < 3) begin
        accCyc[inIdx] = cycleCnt;
        if (inIdx > 0) checkOutput("b2bSpacing", accCyc[inIdx] - accCyc[inIdx-1], PERIOD_BLK);
        inIdx++;
        prevAccept = 1;
      end else if (inIdx < 3) begin
        pt_in = blk[inIdx];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("b2bBlocks", outIdx, 3);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic resetChecks(input string tag);
    checkOutput({tag, "_inReady"}, in_ready, 1);
    checkOutput({tag, "_outValid"}, out_valid, 0);
    checkOutput({tag, "_ct"}, ct_out, 0);
    checkOutput({tag, "_sbValid"}, sb_valid, 0);
    checkOutput({tag, "_sbData"}, sb_data_in, 0);
    checkOutput({tag, "_rkIdx"}, rk_idx, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int p0;
    logic [127:0] pt;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pt_in     = '0;
    buildSbox();
    setKey(FIPS_KEY);

    $display("[TB] reset state");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    resetChecks("reset");
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] FIPS-197 C.1 vector");
    applyStimulus(FIPS_PT, FIPS_CT, 0);

    $display("[TB] back-to-back random blocks");
    setKey(rand128());
    backToBack();

    $display("[TB] backpressure");
    pt = rand128();
    applyStimulus(pt, refEncrypt(pt), 7);

    $display("[TB] reset mid-block");
    setKey(FIPS_KEY);
    p0       = sbPulses;
    in_valid = 1'b1;
    pt_in    = FIPS_PT;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(sb_valid && sbPulses == p0 + 4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("round5Reached", n < 100, 1);
    @(posedge clk);
    #2;
    checkOutput("round5RkIdx", rk_idx, 5);
    rst = 1'b0;
    #1;
    resetChecks("asyncReset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(FIPS_PT, FIPS_CT, 0);

    $display("[TB] timeout");
    setKey(rand128());
    checkOutput("errBeforeTimeout", err, 0);
    p0       = sbPulses;
    in_valid = 1'b1;
    pt_in    = rand128();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(sb_valid && sbPulses == p0 + 2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("round3Reached", n < 100, 1);
    suppress = 1'b1;
    n = 0;
    while (!err && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checkOutput("timeoutWaitCycles", n - 1, TIMEOUT);
    checkOutput("timeoutIdle", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("timeoutNoOut", out_valid, 0);
      @(negedge clk);
    end
    suppress = 1'b0;
    pt = rand128();
    applyStimulus(pt, refEncrypt(pt), 2);
    checkOutput("errSticky", err, 1);

    $display("[TB] spurious strobe");
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    setKey(FIPS_KEY);
    checkOutput("errCleared", err, 0);
    spurious = 1'b1;
    @(posedge clk);
    @(negedge clk);
    spurious = 1'b0;
    checkOutput("spuriousErr", err, 1);
    checkOutput("spuriousIdle", in_ready, 1);
    checkOutput("spuriousNoOut", out_valid, 0);
    applyStimulus(FIPS_PT, FIPS_CT, 1);

    $display("[TB] random keys and blocks");
    for (int k = 0; k < 2; k++) begin
      setKey(rand128());
      pt = rand128();
      applyStimulus(pt, refEncrypt(pt), k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
